// File: rtl/cam_pkg.sv
// Shared types, sizing helper and hit function for the ternary CAM pipeline.
`ifndef CAM_PKG_SV
`define CAM_PKG_SV

// Ternary hit: entry valid and every cared-for bit equal to the compare value.
`define CAM_TERNARY_HIT(vld, data, key, mask) ((vld) && ((((data) ^ (key)) & (mask)) == '0))

package cam_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } cam_state_e;

  // Number of table entries addressed by an index of the given width.
  function automatic int unsigned cam_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

`endif

// File: rtl/cam_ternary_pipe_if.sv
// Lookup request / result handshake bundle for the ternary CAM.
interface cam_ternary_pipe_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned TAG_WIDTH  = 8
);
  import cam_pkg::*;

  localparam int unsigned DEPTH = cam_depth(ADDR_WIDTH);

  logic                  lookup_valid;
  logic                  lookup_ready;
  logic [DATA_WIDTH-1:0] lookup_data;
  logic [TAG_WIDTH-1:0]  lookup_tag;
  logic                  result_valid;
  logic                  result_ready;
  logic                  result_match;
  logic [ADDR_WIDTH-1:0] result_addr;
  logic [DEPTH-1:0]      result_many;
  logic [DEPTH-1:0]      result_single;
  logic [TAG_WIDTH-1:0]  result_tag;

  modport master (
    output lookup_valid, lookup_data, lookup_tag, result_ready,
    input  lookup_ready, result_valid, result_match, result_addr,
           result_many, result_single, result_tag
  );

  modport slave (
    input  lookup_valid, lookup_data, lookup_tag, result_ready,
    output lookup_ready, result_valid, result_match, result_addr,
           result_many, result_single, result_tag
  );

endinterface

// File: rtl/cam_ternary_pipe_priority_encoder.sv
// Priority encoder: picks one winner from a request vector.
module priority_encoder #(
  parameter int unsigned WIDTH        = 32,
  parameter string       LSB_PRIORITY = "HIGH",
  localparam int unsigned AW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [AW-1:0]    addr_c,
  output logic [WIDTH-1:0] single_c,
  output logic             match_c
);

  localparam bit LOW_FIRST = (LSB_PRIORITY == "HIGH");

  // Scan in priority order and keep the first requester found.
  always_comb begin
    logic [AW-1:0] idx;
    logic          found;
    idx      = '0;
    found    = 1'b0;
    addr_c   = '0;
    single_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      idx = LOW_FIRST ? AW'(i) : AW'(WIDTH - 1 - i);
      if (req[idx] && !found) begin
        found          = 1'b1;
        addr_c         = idx;
        single_c[idx]  = 1'b1;
      end
    end
    match_c = found;
  end

endmodule

// File: rtl/cam_ternary_pipe.sv
// Ternary CAM with a two-stage lookup pipeline, flush sweep and occupancy count.
module cam_ternary_pipe
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter string       LSB_PRIORITY = "HIGH"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] write_mask,
  input  logic                  write_delete,
  input  logic                  write_enable,
  output logic                  write_busy,
  input  logic                  flush_start,
  cam_ternary_pipe_if.slave     lk,
  output logic [ADDR_WIDTH:0]   occupancy
);

  localparam int unsigned DEPTH = cam_depth(ADDR_WIDTH);
  localparam int unsigned OCC_W = ADDR_WIDTH + 1;

  cam_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_addr_q, sweep_addr_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DATA_WIDTH-1:0] key_q  [DEPTH];
  logic [DATA_WIDTH-1:0] key_d  [DEPTH];
  logic [DATA_WIDTH-1:0] mask_q [DEPTH];
  logic [DATA_WIDTH-1:0] mask_d [DEPTH];
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [DEPTH-1:0]      s1_hit_q, s1_hit_d;
  logic [TAG_WIDTH-1:0]  s1_tag_q, s1_tag_d;

  logic                  res_valid_q, res_valid_d;
  logic                  res_match_q, res_match_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic [DEPTH-1:0]      res_many_q, res_many_d;
  logic [DEPTH-1:0]      res_single_q, res_single_d;
  logic [TAG_WIDTH-1:0]  res_tag_q, res_tag_d;

  logic [DEPTH-1:0]      hit_c;
  logic                  s2_adv_c, lookup_ready_c, accept_c;
  logic [ADDR_WIDTH-1:0] enc_addr_c;
  logic [DEPTH-1:0]      enc_single_c;
  logic                  enc_match_c;

  // Compare the request against the table as it stands this cycle.
  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_c[i] = `CAM_TERNARY_HIT(valid_q[i], lk.lookup_data, key_q[i], mask_q[i]);
    end
  end

  // Handshake: S2 drains on consume, S1 follows S2, no accepts while sweeping.
  always_comb begin
    s2_adv_c       = !res_valid_q || lk.result_ready;
    lookup_ready_c = (state_q == IDLE) && (!s1_valid_q || s2_adv_c);
    accept_c       = lk.lookup_valid && lookup_ready_c;
  end

  // FSM next state plus table and occupancy updates; flush beats a same-cycle write.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    valid_d      = valid_q;
    key_d        = key_q;
    mask_d       = mask_q;
    occ_d        = occ_q;
    case (state_q)
      IDLE: begin
        if (flush_start) begin
          state_d      = SWEEP;
          sweep_addr_d = '0;
        end else if (write_enable) begin
          if (write_delete) begin
            if (valid_q[write_addr]) occ_d = occ_q - OCC_W'(1);
            valid_d[write_addr] = 1'b0;
          end else begin
            if (!valid_q[write_addr]) occ_d = occ_q + OCC_W'(1);
            valid_d[write_addr] = 1'b1;
            key_d[write_addr]   = write_data;
            mask_d[write_addr]  = write_mask;
          end
        end
      end
      SWEEP: begin
        if (valid_q[sweep_addr_q]) occ_d = occ_q - OCC_W'(1);
        valid_d[sweep_addr_q] = 1'b0;
        sweep_addr_d          = sweep_addr_q + ADDR_WIDTH'(1);
        if (sweep_addr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 captures the hit vector and tag of an accepted request.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_hit_d   = s1_hit_q;
    s1_tag_d   = s1_tag_q;
    if (!s1_valid_q || s2_adv_c) s1_valid_d = accept_c;
    if (accept_c) begin
      s1_hit_d = hit_c;
      s1_tag_d = lk.lookup_tag;
    end
  end

  priority_encoder #(
    .WIDTH        (DEPTH),
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_enc (
    .req      (s1_hit_q),
    .addr_c   (enc_addr_c),
    .single_c (enc_single_c),
    .match_c  (enc_match_c)
  );

  // Stage 2 holds the encoded result until downstream consumes it.
  always_comb begin
    res_valid_d  = res_valid_q;
    res_match_d  = res_match_q;
    res_addr_d   = res_addr_q;
    res_many_d   = res_many_q;
    res_single_d = res_single_q;
    res_tag_d    = res_tag_q;
    if (s2_adv_c) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_match_d  = enc_match_c;
        res_addr_d   = enc_addr_c;
        res_many_d   = s1_hit_q;
        res_single_d = enc_single_c;
        res_tag_d    = s1_tag_q;
      end
    end
  end

  // State registers; reset clears table, pipeline and FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sweep_addr_q <= '0;
      valid_q      <= '0;
      occ_q        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        key_q[i]  <= '0;
        mask_q[i] <= '0;
      end
      s1_valid_q   <= 1'b0;
      s1_hit_q     <= '0;
      s1_tag_q     <= '0;
      res_valid_q  <= 1'b0;
      res_match_q  <= 1'b0;
      res_addr_q   <= '0;
      res_many_q   <= '0;
      res_single_q <= '0;
      res_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      valid_q      <= valid_d;
      occ_q        <= occ_d;
      key_q        <= key_d;
      mask_q       <= mask_d;
      s1_valid_q   <= s1_valid_d;
      s1_hit_q     <= s1_hit_d;
      s1_tag_q     <= s1_tag_d;
      res_valid_q  <= res_valid_d;
      res_match_q  <= res_match_d;
      res_addr_q   <= res_addr_d;
      res_many_q   <= res_many_d;
      res_single_q <= res_single_d;
      res_tag_q    <= res_tag_d;
    end
  end

  assign lk.lookup_ready  = lookup_ready_c;
  assign lk.result_valid  = res_valid_q;
  assign lk.result_match  = res_match_q;
  assign lk.result_addr   = res_addr_q;
  assign lk.result_many   = res_many_q;
  assign lk.result_single = res_single_q;
  assign lk.result_tag    = res_tag_q;
  assign write_busy       = (state_q == SWEEP);
  assign occupancy        = occ_q;

endmodule

// File: tb/tb_cam_ternary_pipe.sv
// Self-checking bench for cam_ternary_pipe: table model plus in-order result scoreboard.
module tb_cam_ternary_pipe;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 5;
  localparam int unsigned TW    = 8;
  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic [DEPTH-1:0] many;
    logic [DEPTH-1:0] single;
    logic [AW-1:0]    addr;
    logic             match;
    logic [TW-1:0]    tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] write_mask;
  logic          write_delete;
  logic          write_enable;
  logic          write_busy;
  logic          flush_start;
  logic [AW:0]   occupancy;

  cam_ternary_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) lk ();

  cam_ternary_pipe #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .TAG_WIDTH    (TW),
    .LSB_PRIORITY ("HIGH")
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_mask   (write_mask),
    .write_delete (write_delete),
    .write_enable (write_enable),
    .write_busy   (write_busy),
    .flush_start  (flush_start),
    .lk           (lk),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   n_results = 0;
  exp_t sb[$];

  logic          m_valid [DEPTH];
  logic [DW-1:0] m_key   [DEPTH];
  logic [DW-1:0] m_mask  [DEPTH];
  int            m_sweep = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_lookup(input logic [DW-1:0] d, input logic [TW-1:0] tag);
    exp_t e;
    e     = '0;
    e.tag = tag;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && (((d ^ m_key[i]) & m_mask[i]) == '0)) e.many[i] = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (e.many[i]) begin
        e.addr  = AW'(i);
        e.match = 1'b1;
      end
    if (e.match) e.single[e.addr] = 1'b1;
    return e;
  endfunction

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  // Scoreboard and table model, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      m_sweep = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_key[i]   = '0;
        m_mask[i]  = '0;
      end
    end else begin
      if (m_sweep == 0) check("occupancy_model", 64'(occupancy), 64'(model_count()));
      if (lk.result_valid && lk.result_ready) begin
        if (sb.size() == 0) begin
          check("result_without_request", 64'(lk.result_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("res_tag",    64'(lk.result_tag),    64'(e.tag));
          check("res_match",  64'(lk.result_match),  64'(e.match));
          check("res_addr",   64'(lk.result_addr),   64'(e.addr));
          check("res_many",   64'(lk.result_many),   64'(e.many));
          check("res_single", 64'(lk.result_single), 64'(e.single));
          n_results++;
        end
      end
      if (lk.lookup_valid && lk.lookup_ready)
        sb.push_back(model_lookup(lk.lookup_data, lk.lookup_tag));
      if (m_sweep > 0) begin
        m_sweep--;
      end else if (flush_start) begin
        m_sweep = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      end else if (write_enable) begin
        if (write_delete) begin
          m_valid[write_addr] = 1'b0;
        end else begin
          m_valid[write_addr] = 1'b1;
          m_key[write_addr]   = write_data;
          m_mask[write_addr]  = write_mask;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m,
                    input logic del);
    write_enable = 1'b1;
    write_addr   = a;
    write_data   = d;
    write_mask   = m;
    write_delete = del;
    tick();
    write_enable = 1'b0;
    write_delete = 1'b0;
  endtask

  task automatic lookup_one(input logic [DW-1:0] d, input logic [TW-1:0] tag);
    logic rdy;
    rdy             = 1'b0;
    lk.lookup_valid = 1'b1;
    lk.lookup_data  = d;
    lk.lookup_tag   = tag;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = lk.lookup_ready;
      if (rdy) break;
    end
    check("lookup_accept", 64'(rdy), 64'(1));
    tick();
    lk.lookup_valid = 1'b0;
  endtask

  task automatic get_result(output exp_t r);
    logic got;
    got = 1'b0;
    r   = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (lk.result_valid && lk.result_ready) begin
        got      = 1'b1;
        r.many   = lk.result_many;
        r.single = lk.result_single;
        r.addr   = lk.result_addr;
        r.match  = lk.result_match;
        r.tag    = lk.result_tag;
        break;
      end
    end
    check("result_arrives", 64'(got), 64'(1));
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    exp_t r;
    int   busy_cnt;
    int   base;
    rst             = 1'b1;
    write_addr      = '0;
    write_data      = '0;
    write_mask      = '0;
    write_delete    = 1'b0;
    write_enable    = 1'b0;
    flush_start     = 1'b0;
    lk.lookup_valid = 1'b0;
    lk.lookup_data  = '0;
    lk.lookup_tag   = '0;
    lk.result_ready = 1'b1;

    // Reset state.
    #2;
    check("rst_result_valid", 64'(lk.result_valid), 64'(0));
    check("rst_write_busy",   64'(write_busy),      64'(0));
    check("rst_occupancy",    64'(occupancy),       64'(0));
    check("rst_result_many",  64'(lk.result_many),  64'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(lk.lookup_ready), 64'(1));
    tick();

    // Basic ternary match and two-cycle latency.
    wr(5'd3, 64'h00FF, 64'hFFFF, 1'b0);
    wr(5'd1, 64'h0000, 64'h0000, 1'b0);
    lk.lookup_valid = 1'b1;
    lk.lookup_data  = 64'h00FF;
    lk.lookup_tag   = 8'h5A;
    tick();
    lk.lookup_valid = 1'b0;
    @(negedge clk);
    check("t1_not_yet_valid", 64'(lk.result_valid), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_valid_t2",  64'(lk.result_valid),  64'(1));
    check("t1_match",     64'(lk.result_match),  64'(1));
    check("t1_addr",      64'(lk.result_addr),   64'(1));
    check("t1_many",      64'(lk.result_many),   64'(32'b1010));
    check("t1_single",    64'(lk.result_single), 64'(32'b0010));
    check("t1_tag",       64'(lk.result_tag),    64'(8'h5A));
    check("t1_occupancy", 64'(occupancy),        64'(2));
    tick();
    drain();

    // Same-cycle write is invisible, next-cycle lookup sees it.
    do_reset();
    write_enable    = 1'b1;
    write_addr      = 5'd0;
    write_data      = 64'hAB;
    write_mask      = '1;
    write_delete    = 1'b0;
    lk.lookup_valid = 1'b1;
    lk.lookup_data  = 64'hAB;
    lk.lookup_tag   = 8'h31;
    tick();
    write_enable    = 1'b0;
    lk.lookup_tag   = 8'h32;
    tick();
    lk.lookup_valid = 1'b0;
    get_result(r);
    check("coh_first_match",  64'(r.match), 64'(0));
    check("coh_first_tag",    64'(r.tag),   64'(8'h31));
    get_result(r);
    check("coh_second_match", 64'(r.match), 64'(1));
    check("coh_second_addr",  64'(r.addr),  64'(0));
    drain();

    // Back-to-back lookups with a three-cycle downstream stall.
    wr(5'd9, 64'h1200, 64'hFF00, 1'b0);
    base = n_results;
    lk.lookup_valid = 1'b1;
    lk.lookup_data  = 64'hAB;
    lk.lookup_tag   = 8'd1;
    tick();
    lk.lookup_data  = 64'h1234;
    lk.lookup_tag   = 8'd2;
    tick();
    lk.lookup_data  = 64'h12AB;
    lk.lookup_tag   = 8'd3;
    lk.result_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready_low", 64'(lk.lookup_ready), 64'(0));
      check("stall_hold_tag",  64'(lk.result_tag),   64'(1));
      @(posedge clk);
      #1;
    end
    lk.result_ready = 1'b1;
    lookup_one(64'h12AB, 8'd3);
    lookup_one(64'h5555, 8'd4);
    drain();
    check("stall_result_count", 64'(n_results - base), 64'(4));

    // Occupancy accounting across delete, repeated delete and overwrite.
    do_reset();
    wr(5'd2, 64'h1, 64'hFF, 1'b0);
    wr(5'd4, 64'h2, 64'hFF, 1'b0);
    check("occ_two", 64'(occupancy), 64'(2));
    wr(5'd2, 64'h0, 64'h0, 1'b1);
    check("occ_delete", 64'(occupancy), 64'(1));
    wr(5'd2, 64'h0, 64'h0, 1'b1);
    check("occ_delete_again", 64'(occupancy), 64'(1));
    wr(5'd4, 64'h3, 64'hFF, 1'b0);
    check("occ_overwrite", 64'(occupancy), 64'(1));
    lookup_one(64'h1, 8'h44);
    get_result(r);
    check("deleted_no_match", 64'(r.match), 64'(0));
    drain();

    // Fill the table, then flush; writes and flushes during the sweep are dropped.
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 64'(i), '1, 1'b0);
    check("occ_full", 64'(occupancy), 64'(DEPTH));
    write_enable = 1'b1;
    write_delete = 1'b1;
    write_addr   = 5'd0;
    flush_start  = 1'b1;
    tick();
    flush_start  = 1'b0;
    write_enable = 1'b0;
    write_delete = 1'b0;
    busy_cnt     = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!write_busy) break;
      busy_cnt++;
      check("sweep_ready_low", 64'(lk.lookup_ready), 64'(0));
      @(posedge clk);
      #1;
      write_enable = (k == 10);
      write_addr   = 5'd2;
      write_data   = '0;
      write_mask   = '0;
      flush_start  = (k == 12);
    end
    write_enable = 1'b0;
    flush_start  = 1'b0;
    tick();
    check("sweep_cycles",    64'(busy_cnt),  64'(32));
    check("occ_after_flush", 64'(occupancy), 64'(0));
    lookup_one(64'h0, 8'hC0);
    get_result(r);
    check("flush_no_match", 64'(r.match), 64'(0));
    drain();

    // Asynchronous reset in the middle of a sweep with a stalled result.
    wr(5'd7, 64'h0, 64'h0, 1'b0);
    lk.result_ready = 1'b0;
    lookup_one(64'h0, 8'h77);
    tick();
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    tick();
    tick();
    check("stall_setup_valid", 64'(lk.result_valid), 64'(1));
    check("stall_setup_busy",  64'(write_busy),      64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("arst_result_valid",  64'(lk.result_valid),  64'(0));
    check("arst_result_match",  64'(lk.result_match),  64'(0));
    check("arst_result_addr",   64'(lk.result_addr),   64'(0));
    check("arst_result_many",   64'(lk.result_many),   64'(0));
    check("arst_result_single", 64'(lk.result_single), 64'(0));
    check("arst_result_tag",    64'(lk.result_tag),    64'(0));
    check("arst_write_busy",    64'(write_busy),       64'(0));
    check("arst_occupancy",     64'(occupancy),        64'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst             = 1'b0;
    lk.result_ready = 1'b1;
    @(negedge clk);
    check("arst_ready_after", 64'(lk.lookup_ready), 64'(1));
    check("arst_busy_after",  64'(write_busy),      64'(0));
    tick();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
